// File: rtl/sign_narrow_if.sv
// sign_narrow_if: groups the narrowing unit's input stream, output stream and
// overflow-counter signals. The producer/consumer side uses the master
// modport, and the narrowing unit uses the slave modport.
interface sign_narrow_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_data;
    logic             out_fits;
    logic             clear_count;
    logic [CNT_W-1:0] ovf_count;

    modport master (
        output in_valid, in_data, out_ready, clear_count,
        input  in_ready, out_valid, out_data, out_fits, ovf_count
    );

    modport slave (
        input  in_valid, in_data, out_ready, clear_count,
        output in_ready, out_valid, out_data, out_fits, ovf_count
    );
endinterface

// File: rtl/sign_narrow.sv
// sign_narrow: streaming 32->16 signed narrowing unit with a 2-entry output
// buffer and a saturating count of words that did not fit in 16 bits.
// Optional feature macro: SIGN_NARROW_SAT_EN. When it is defined, non-fitting
// words clamp to 16'h7FFF or 16'h8000. When it is undefined, they are truncated.
module sign_narrow #(
    parameter int CNT_W = 16
) (
    input  logic         clk,
    input  logic         reset,
    sign_narrow_if.slave sn
);
    // Buffer occupancy states
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef struct packed {
        logic [15:0] data;
        logic        fits;
    } entry_t;

    logic [1:0]       state_q, state_d;
    entry_t           head_q, head_d;
    entry_t           tail_q, tail_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    entry_t new_e;
    logic   accept;
    logic   pop;

    // A word fits when bits 31..15 are all copies of the sign bit
    function automatic entry_t narrow(input logic [31:0] w);
        entry_t e;
        e.fits = (&w[31:15]) | ~(|w[31:15]);
`ifdef SIGN_NARROW_SAT_EN
        if (e.fits)
            e.data = w[15:0];
        else
            e.data = w[31] ? 16'h8000 : 16'h7FFF;
`else
        e.data = w[15:0];
`endif
        return e;
    endfunction

    assign new_e = narrow(sn.in_data);

    // Handshake outputs depend only on registered state. There is no
    // combinational path from out_ready to in_ready.
    assign sn.in_ready  = (state_q != ST_TWO);
    assign sn.out_valid = (state_q != ST_EMPTY);
    assign sn.out_data  = head_q.data;
    assign sn.out_fits  = head_q.fits;
    assign sn.ovf_count = cnt_q;

    assign accept = sn.in_valid  && sn.in_ready;
    assign pop    = sn.out_valid && sn.out_ready;

    // Occupancy and buffer next state. The head always holds the oldest entry.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            ST_EMPTY: begin
                // pop is impossible here because out_valid is 0
                if (accept) begin
                    head_d  = new_e;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && pop) begin
                    head_d = new_e;          // head is replaced and the state stays ONE
                end else if (accept) begin
                    tail_d  = new_e;
                    state_d = ST_TWO;
                end else if (pop) begin
                    state_d = ST_EMPTY;      // stale head is kept, but out_valid is 0
                end
            end
            ST_TWO: begin
                // accept is impossible here because in_ready is 0
                if (pop) begin
                    head_d  = tail_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Overflow counter: clear wins, then saturating increment on a non-fitting accept
    always_comb begin
        cnt_d = cnt_q;
        if (sn.clear_count)
            cnt_d = '0;
        else if (accept && !new_e.fits && cnt_q != CNT_MAX)
            cnt_d = cnt_q + 1'b1;
    end

    // State registers with synchronous reset; reset drops any buffered entries
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule
